// File: rtl/rr_arb3_gnt.sv
// Three-requester round-robin arbiter with a fixed REQ2GNT-cycle request-to-grant pipeline.
// Grants and gnt_id leave straight from the last pipeline stage; rr_ptr is the debug pointer.
`timescale 1ns/1ps
module rr_arb3_gnt #(
  parameter int unsigned REQ2GNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic [1:0] gnt_id,
  output logic [1:0] rr_ptr
);

  localparam int unsigned LAST = REQ2GNT - 1;

  if (REQ2GNT < 1 || REQ2GNT > 8) begin : g_bad_latency
    $fatal(1, "rr_arb3_gnt: REQ2GNT must be within 1..8");
  end

  logic [2:0] req_vec;
  logic [2:0] win_vec;
  logic [1:0] win_id;
  logic [1:0] ptr_next;

  assign req_vec = {req3, req2, req1};

  // Rotating-priority pick; rr_ptr names the client with top priority.
  always_comb begin
    win_vec = 3'b000;
    win_id  = 2'd0;
    case (rr_ptr)
      2'd2: begin
        if      (req_vec[1]) begin win_vec = 3'b010; win_id = 2'd2; end
        else if (req_vec[2]) begin win_vec = 3'b100; win_id = 2'd3; end
        else if (req_vec[0]) begin win_vec = 3'b001; win_id = 2'd1; end
      end
      2'd3: begin
        if      (req_vec[2]) begin win_vec = 3'b100; win_id = 2'd3; end
        else if (req_vec[0]) begin win_vec = 3'b001; win_id = 2'd1; end
        else if (req_vec[1]) begin win_vec = 3'b010; win_id = 2'd2; end
      end
      default: begin
        if      (req_vec[0]) begin win_vec = 3'b001; win_id = 2'd1; end
        else if (req_vec[1]) begin win_vec = 3'b010; win_id = 2'd2; end
        else if (req_vec[2]) begin win_vec = 3'b100; win_id = 2'd3; end
      end
    endcase
  end

  // Pointer moves to the client after the winner; 0 is never produced.
  always_comb begin
    ptr_next = rr_ptr;
    case (win_id)
      2'd1:    ptr_next = 2'd2;
      2'd2:    ptr_next = 2'd3;
      2'd3:    ptr_next = 2'd1;
      default: ptr_next = rr_ptr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 2'd1;
    end else if (win_id != 2'd0) begin
      rr_ptr <= ptr_next;
    end
  end

  // Each stage carries {gnt_id, gnt3, gnt2, gnt1} so the encoding stays aligned.
  for (genvar s = 0; s < REQ2GNT; s++) begin : g_stage
    logic [4:0] q;
    if (s == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) q <= 5'b0;
        else       q <= {win_id, win_vec};
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) q <= 5'b0;
        else       q <= g_stage[s-1].q;
      end
    end
  end

  assign {gnt_id, gnt3, gnt2, gnt1} = g_stage[LAST].q;

endmodule

// File: tb/tb_rr_arb3_gnt.sv
// Bench for rr_arb3_gnt: three instances (REQ2GNT = 1, 2, 8) share one request stream,
// checked by a per-instance scoreboard plus scenario tasks with explicit expectations.
`timescale 1ns/1ps
module tb_rr_arb3_gnt;

  localparam int NI = 3;

  logic clk;
  logic reset;
  logic req1, req2, req3;
  logic [2:0] gv0, gv1, gv2;
  logic [1:0] gi0, gi1, gi2;
  logic [1:0] pt0, pt1, pt2;

  int checks = 0;
  int errors = 0;

  rr_arb3_gnt #(.REQ2GNT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .req3(req3),
    .gnt1(gv0[0]), .gnt2(gv0[1]), .gnt3(gv0[2]), .gnt_id(gi0), .rr_ptr(pt0));
  rr_arb3_gnt #(.REQ2GNT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .req3(req3),
    .gnt1(gv1[0]), .gnt2(gv1[1]), .gnt3(gv1[2]), .gnt_id(gi1), .rr_ptr(pt1));
  rr_arb3_gnt #(.REQ2GNT(8)) u_lat8 (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .req3(req3),
    .gnt1(gv2[0]), .gnt2(gv2[1]), .gnt3(gv2[2]), .gnt_id(gi2), .rr_ptr(pt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  // Observed {gnt_id, gnt3, gnt2, gnt1} of instance i.
  function automatic logic [4:0] obs(int i);
    case (i)
      0:       return {gi0, gv0};
      1:       return {gi1, gv1};
      default: return {gi2, gv2};
    endcase
  endfunction

  function automatic logic [1:0] optr(int i);
    case (i)
      0:       return pt0;
      1:       return pt1;
      default: return pt2;
    endcase
  endfunction

  // Expected output word for winner w (0 = no grant).
  function automatic logic [4:0] enc(int w);
    case (w)
      1:       return 5'b01_001;
      2:       return 5'b10_010;
      3:       return 5'b11_100;
      default: return 5'b00_000;
    endcase
  endfunction

  function automatic int model_pick(logic [2:0] r, int p);
    int w;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = ((p - 1 + k) % 3) + 1;
      if (w == 0 && r[c-1] === 1'b1) w = c;
    end
    return w;
  endfunction

  int sb0[$];
  int sb1[$];
  int sb2[$];
  int mptr;
  bit armed = 0;

  task automatic sb_push(input int i, input int w);
    case (i)
      0:       sb0.push_back(w);
      1:       sb1.push_back(w);
      default: sb2.push_back(w);
    endcase
  endtask

  task automatic sb_clear();
    sb0.delete();
    sb1.delete();
    sb2.delete();
  endtask

  task automatic sb_pop(input int i, output int w, output bit ok);
    ok = 1'b0;
    w  = 0;
    case (i)
      0:       if (sb0.size() >= lat(0)) begin w = sb0.pop_front(); ok = 1'b1; end
      1:       if (sb1.size() >= lat(1)) begin w = sb1.pop_front(); ok = 1'b1; end
      default: if (sb2.size() >= lat(2)) begin w = sb2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Scoreboard: model decision pushed at each sampling edge, matching output popped #1 later.
  always @(posedge clk) begin : scoreboard
    logic [2:0] r;
    int w;
    int e;
    bit ok;
    r = {req3, req2, req1};
    if (reset) begin
      mptr = 1;
      sb_clear();
      for (int i = 0; i < NI; i++)
        for (int k = 0; k < lat(i); k++) sb_push(i, 0);
      armed = 1'b1;
    end else if (armed) begin
      w = model_pick(r, mptr);
      if (w != 0) mptr = (w % 3) + 1;
      for (int i = 0; i < NI; i++) sb_push(i, w);
    end
    #1;
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        sb_pop(i, e, ok);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL sb_underflow lat=%0d: scoreboard had no expected entry", lat(i));
        end else if (obs(i) !== enc(e)) begin
          errors++;
          $display("FAIL sb_grant lat=%0d t=%0t: got {id,gnt}=%b, expected %b", lat(i), $time, obs(i), enc(e));
        end
        checks++;
        if (optr(i) !== 2'(mptr)) begin
          errors++;
          $display("FAIL sb_rr_ptr lat=%0d t=%0t: got %0d, expected %0d", lat(i), $time, optr(i), mptr);
        end
      end
    end
  end

  task automatic set_req(input logic a, input logic b, input logic c);
    req1 = a;
    req2 = b;
    req3 = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1'bx, 1'bx, 1'bx);
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs(i) !== 5'b0) begin
        errors++;
        $display("FAIL reset_grants lat=%0d: got %b, expected 00000", lat(i), obs(i));
      end
      checks++;
      if (optr(i) !== 2'd1) begin
        errors++;
        $display("FAIL reset_rr_ptr lat=%0d: got %0d, expected 1", lat(i), optr(i));
      end
    end
    set_req(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Lone req1 for one edge; pointer starts at 1 and moves to 2.
  task automatic test_single();
    set_req(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs(i) !== ((j == lat(i) - 1) ? enc(1) : enc(0))) begin
          errors++;
          $display("FAIL single lat=%0d step=%0d: got %b, expected %b", lat(i), j, obs(i),
                   (j == lat(i) - 1) ? enc(1) : enc(0));
        end
      end
    end
  endtask

  // All three requesting for 12 edges from rr_ptr = 2: winners 2,3,1,2,3,1,...
  task automatic test_contention();
    set_req(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int idx;
        logic [4:0] exp;
        idx = j - lat(i) + 1;
        exp = (idx >= 0) ? enc(((1 + idx) % 3) + 1) : enc(0);
        checks++;
        if (obs(i) !== exp || $countones(obs(i)) > 3 || $countones(obs(i) & 5'b00111) > 1) begin
          errors++;
          $display("FAIL contention lat=%0d step=%0d: got %b, expected %b", lat(i), j, obs(i), exp);
        end
      end
    end
    set_req(1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  // Lone req2 (ptr 2 -> 3), then req1+req3 for two edges: winners 2,3,1.
  task automatic test_back_to_back();
    int dec[3] = '{2, 3, 1};
    int ptr_exp[3] = '{3, 1, 2};
    set_req(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      if (j == 0) set_req(1'b1, 1'b0, 1'b1);
      if (j == 2) set_req(1'b0, 1'b0, 1'b0);
      if (j < 3) begin
        checks++;
        if (pt1 !== 2'(ptr_exp[j])) begin
          errors++;
          $display("FAIL steer_rr_ptr step=%0d: got %0d, expected %0d", j, pt1, ptr_exp[j]);
        end
      end
      for (int i = 0; i < NI; i++) begin
        int idx;
        logic [4:0] exp;
        idx = j - lat(i) + 1;
        exp = (idx >= 0 && idx < 3) ? enc(dec[idx]) : enc(0);
        checks++;
        if (obs(i) !== exp) begin
          errors++;
          $display("FAIL steer lat=%0d step=%0d: got %b, expected %b", lat(i), j, obs(i), exp);
        end
      end
    end
  endtask

  // req2 wins (ptr -> 3), five idle cycles hold the pointer, then req1+req2 gives req1.
  task automatic test_idle_hold();
    int dec[7] = '{2, 0, 0, 0, 0, 0, 1};
    set_req(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) set_req(1'b0, 1'b0, 1'b0);
      if (j == 5) set_req(1'b1, 1'b1, 1'b0);
      if (j == 6) set_req(1'b0, 1'b0, 1'b0);
      if (j < 7) begin
        checks++;
        if (pt0 !== ((j < 6) ? 2'd3 : 2'd2)) begin
          errors++;
          $display("FAIL idle_rr_ptr step=%0d: got %0d, expected %0d", j, pt0, (j < 6) ? 3 : 2);
        end
      end
      for (int i = 0; i < NI; i++) begin
        int idx;
        logic [4:0] exp;
        idx = j - lat(i) + 1;
        exp = (idx >= 0 && idx < 7) ? enc(dec[idx]) : enc(0);
        checks++;
        if (obs(i) !== exp) begin
          errors++;
          $display("FAIL idle lat=%0d step=%0d: got %b, expected %b", lat(i), j, obs(i), exp);
        end
      end
    end
  endtask

  // Reset pulse under full contention discards in-flight grants; req1 wins first afterwards.
  task automatic test_reset_midflight();
    set_req(1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs(i) !== 5'b0 || optr(i) !== 2'd1) begin
        errors++;
        $display("FAIL midreset_clear lat=%0d: got gnt=%b ptr=%0d, expected 00000 ptr=1",
                 lat(i), obs(i), optr(i));
      end
    end
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (m <= lat(i) - 1) begin
          logic [4:0] exp;
          exp = (m == lat(i) - 1) ? enc(1) : enc(0);
          checks++;
          if (obs(i) !== exp) begin
            errors++;
            $display("FAIL midreset lat=%0d step=%0d: got %b, expected %b", lat(i), m, obs(i), exp);
          end
        end
      end
    end
    set_req(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0);
    test_reset();
    test_single();
    repeat (10) @(negedge clk);
    test_contention();
    test_back_to_back();
    test_idle_hold();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
